// File: rtl/hdmi_quad_osd_pkg.sv
// osd_pkg: shared constants for the hdmi_quad_osd overlay stage.
// Optional border grid is controlled by the OSD_BORDER_EN macro.
package osd_pkg;

   localparam int H_ACTIVE_DEF = 1920;
   localparam int V_ACTIVE_DEF = 1080;

   // Quadrant code is {lower half, right half}.
   typedef enum logic [1:0] {
      Q_HDMI = 2'd0,
      Q_UDP  = 2'd1,
      Q_VGAA = 2'd2,
      Q_VGAB = 2'd3
   } quad_e;

`ifdef OSD_BORDER_EN
   localparam logic [23:0] BORDER_RGB_DEF = 24'hFFFFFF;
`endif
   localparam logic [23:0] NOSIG_RGB_DEF  = 24'h0000FF;

   // Position counters stop here instead of wrapping on over-long lines.
   localparam logic [10:0] POS_MAX = 11'h7FF;

   // True when pos lies in the half-open band [lo, hi).
   function automatic logic in_band(input logic [10:0] pos, input logic [10:0] lo,
                                    input logic [10:0] hi);
      return (pos >= lo) && (pos < hi);
   endfunction

endpackage

// File: rtl/hdmi_quad_osd_if.sv
// hdmi_quad_osd_if: video timing/pixel bundle in and out of the overlay stage.
// The master is the side that produces vs_in/hs_in/de_in/rgb_in.
// There is no back-pressure: every pix_clk cycle carries one sample.
interface hdmi_quad_osd_if;
   logic        vs_in;
   logic        hs_in;
   logic        de_in;
   logic [23:0] rgb_in;
   logic        vs_out;
   logic        hs_out;
   logic        de_out;
   logic [23:0] rgb_out;

   modport master (output vs_in, hs_in, de_in, rgb_in,
                   input  vs_out, hs_out, de_out, rgb_out);
   modport slave  (input  vs_in, hs_in, de_in, rgb_in,
                   output vs_out, hs_out, de_out, rgb_out);
endinterface

// File: rtl/hdmi_quad_osd_frame_alive_mon.sv
// frame_alive_mon: decides whether one frame-buffer writer is still producing
// frames, by watching its write frame number change across output frames.
module frame_alive_mon #(
   parameter int STALE_FRAMES = 8
) (
   input  logic       pix_clk,
   input  logic       rst_n,
   input  logic [1:0] frame_num,
   input  logic       vs_rise,
   output logic       alive
);
   localparam logic [3:0] STALE_MAX = 4'(STALE_FRAMES);

   logic [1:0] sync_a;
   logic [1:0] sync_b;
   logic [1:0] last_val;
   logic [3:0] stale_cnt;
   logic [3:0] cnt_nxt;

   // Two-flop synchroniser from the write clock domain; a torn sample only
   // costs one extra frame of apparent liveness.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= frame_num;
         sync_b <= sync_a;
      end
   end

   // A fresh nonzero frame number restarts the count; anything else ages it.
   always_comb begin
      cnt_nxt = stale_cnt;
      if ((sync_b != 2'd0) && (sync_b != last_val)) cnt_nxt = 4'd0;
      else if (stale_cnt < STALE_MAX)               cnt_nxt = stale_cnt + 4'd1;
   end

   // Liveness state only moves at frame start so it is steady across a frame.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         last_val  <= '0;
         stale_cnt <= STALE_MAX;
         alive     <= 1'b0;
      end else if (vs_rise) begin
         last_val  <= sync_b;
         stale_cnt <= cnt_nxt;
         alive     <= (cnt_nxt < STALE_MAX);
      end
   end
endmodule

// File: rtl/hdmi_quad_osd.sv
// hdmi_quad_osd: splits the output raster into four quadrants (HDMI-in, UDP,
// VGA-A, VGA-B), blanks dead sources with a flat colour and optionally draws a
// border grid (OSD_BORDER_EN). Two-stage pipeline, latency 2 on every output.
module hdmi_quad_osd
   import osd_pkg::*;
#(
   parameter int          H_ACTIVE     = H_ACTIVE_DEF,
   parameter int          V_ACTIVE     = V_ACTIVE_DEF,
`ifdef OSD_BORDER_EN
   parameter int          BORDER_W     = 2,
   parameter logic [23:0] BORDER_RGB   = BORDER_RGB_DEF,
`endif
   parameter logic [23:0] NOSIG_RGB    = NOSIG_RGB_DEF,
   parameter int          STALE_FRAMES = 8
) (
   input  logic            pix_clk,
   input  logic            rst_n,
   hdmi_quad_osd_if.slave  vid,
   input  logic [1:0]      wr_hdmi_frame,
   input  logic [1:0]      wr_udp_frame,
   input  logic [1:0]      wr_vgaa_frame,
   input  logic [1:0]      wr_vgab_frame,
   output logic [3:0]      src_alive
);
   localparam logic [10:0] X_MID = 11'(H_ACTIVE / 2);
   localparam logic [10:0] Y_MID = 11'(V_ACTIVE / 2);

   logic        vs_prev;
   logic        de_prev;
   logic        vs_rise;
   logic        de_fall;
   logic        frame_valid;
   logic [10:0] x;
   logic [10:0] y;

   logic        vs_s1;
   logic        hs_s1;
   logic        de_s1;
   logic [23:0] rgb_s1;
   quad_e       q_s1;
   logic [23:0] pix_nxt;

   assign vs_rise = vid.vs_in & ~vs_prev;
   assign de_fall = de_prev & ~vid.de_in;

`ifdef OSD_BORDER_EN
   localparam logic [10:0] X_BLO = 11'(H_ACTIVE / 2 - BORDER_W / 2);
   localparam logic [10:0] X_BHI = 11'(H_ACTIVE / 2 + BORDER_W / 2);
   localparam logic [10:0] X_ELO = 11'(BORDER_W / 2);
   localparam logic [10:0] X_EHI = 11'(H_ACTIVE - BORDER_W / 2);
   localparam logic [10:0] Y_BLO = 11'(V_ACTIVE / 2 - BORDER_W / 2);
   localparam logic [10:0] Y_BHI = 11'(V_ACTIVE / 2 + BORDER_W / 2);
   localparam logic [10:0] Y_ELO = 11'(BORDER_W / 2);
   localparam logic [10:0] Y_EHI = 11'(V_ACTIVE - BORDER_W / 2);

   logic border_now;
   logic border_s1;

   // Centre cross plus outer frame; saturated x past the edge lands in X_EHI.
   assign border_now = in_band(x, X_BLO, X_BHI) || (x < X_ELO) || (x >= X_EHI) ||
                       in_band(y, Y_BLO, Y_BHI) || (y < Y_ELO) || (y >= Y_EHI);
`endif

   // One liveness monitor per source, bit order {vgab, vgaa, udp, hdmi}.
   frame_alive_mon #(.STALE_FRAMES(STALE_FRAMES)) u_mon_hdmi (
      .pix_clk(pix_clk), .rst_n(rst_n), .frame_num(wr_hdmi_frame), .vs_rise(vs_rise),
      .alive(src_alive[0]));
   frame_alive_mon #(.STALE_FRAMES(STALE_FRAMES)) u_mon_udp (
      .pix_clk(pix_clk), .rst_n(rst_n), .frame_num(wr_udp_frame), .vs_rise(vs_rise),
      .alive(src_alive[1]));
   frame_alive_mon #(.STALE_FRAMES(STALE_FRAMES)) u_mon_vgaa (
      .pix_clk(pix_clk), .rst_n(rst_n), .frame_num(wr_vgaa_frame), .vs_rise(vs_rise),
      .alive(src_alive[2]));
   frame_alive_mon #(.STALE_FRAMES(STALE_FRAMES)) u_mon_vgab (
      .pix_clk(pix_clk), .rst_n(rst_n), .frame_num(wr_vgab_frame), .vs_rise(vs_rise),
      .alive(src_alive[3]));

   // Sync edge history; output stays black until a full frame start is seen.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_prev     <= 1'b0;
         de_prev     <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         vs_prev <= vid.vs_in;
         de_prev <= vid.de_in;
         if (vs_rise) frame_valid <= 1'b1;
      end
   end

   // Raster position of the pixel currently on rgb_in; both counters saturate.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else begin
         if (vid.de_in) begin
            if (x != POS_MAX) x <= x + 11'd1;
         end else begin
            x <= '0;
         end
         if (vs_rise)                        y <= '0;
         else if (de_fall && (y != POS_MAX)) y <= y + 11'd1;
      end
   end

   // Stage 1: position decisions and the delayed stream.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_s1     <= 1'b0;
         hs_s1     <= 1'b0;
         de_s1     <= 1'b0;
         rgb_s1    <= '0;
         q_s1      <= Q_HDMI;
`ifdef OSD_BORDER_EN
         border_s1 <= 1'b0;
`endif
      end else begin
         vs_s1     <= vid.vs_in;
         hs_s1     <= vid.hs_in;
         de_s1     <= vid.de_in;
         rgb_s1    <= vid.rgb_in;
         q_s1      <= quad_e'({(y >= Y_MID), (x >= X_MID)});
`ifdef OSD_BORDER_EN
         border_s1 <= border_now;
`endif
      end
   end

   // Pixel priority: blanking/invalid, border, dead source, live video.
   always_comb begin
      pix_nxt = rgb_s1;
      if (!de_s1 || !frame_valid)  pix_nxt = '0;
`ifdef OSD_BORDER_EN
      else if (border_s1)          pix_nxt = BORDER_RGB;
`endif
      else if (!src_alive[q_s1])   pix_nxt = NOSIG_RGB;
   end

   // Stage 2: registered outputs.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         vid.vs_out  <= 1'b0;
         vid.hs_out  <= 1'b0;
         vid.de_out  <= 1'b0;
         vid.rgb_out <= '0;
      end else begin
         vid.vs_out  <= vs_s1;
         vid.hs_out  <= hs_s1;
         vid.de_out  <= de_s1;
         vid.rgb_out <= pix_nxt;
      end
   end
endmodule
